// File: rtl/axi4lite_cmd_manager.sv
// AXI4-Lite manager: executes one register command as a single AXI4-Lite
// write or read, returns one response, and bounds the response wait with a
// per-command timeout that never withdraws an asserted valid.
module axi4lite_cmd_manager #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        aclk,
    input  logic        aresetn,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_timeout,
    output logic [31:0] m_axi_lite_awaddr,
    output logic [2:0]  m_axi_lite_awprot,
    output logic        m_axi_lite_awvalid,
    input  logic        m_axi_lite_awready,
    output logic [31:0] m_axi_lite_wdata,
    output logic [3:0]  m_axi_lite_wstrb,
    output logic        m_axi_lite_wvalid,
    input  logic        m_axi_lite_wready,
    input  logic [1:0]  m_axi_lite_bresp,
    input  logic        m_axi_lite_bvalid,
    output logic        m_axi_lite_bready,
    output logic [31:0] m_axi_lite_araddr,
    output logic [2:0]  m_axi_lite_arprot,
    output logic        m_axi_lite_arvalid,
    input  logic        m_axi_lite_arready,
    input  logic [31:0] m_axi_lite_rdata,
    input  logic [1:0]  m_axi_lite_rresp,
    input  logic        m_axi_lite_rvalid,
    output logic        m_axi_lite_rready
);

    localparam logic [31:0] TIMEOUT_W = 32'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, BUSY, RESP, DRAIN} state_t;

    state_t      state, state_next;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic        awvalid_q, wvalid_q, bready_q, arvalid_q, rready_q;
    logic        b_pend, r_pend;
    logic [31:0] tmo_cnt;

    logic accept, aw_hs, w_hs, b_hs, ar_hs, r_hs, expire, pend_next;

    assign accept = cmd_valid & cmd_ready;
    assign aw_hs  = awvalid_q & m_axi_lite_awready;
    assign w_hs   = wvalid_q & m_axi_lite_wready;
    assign b_hs   = bready_q & m_axi_lite_bvalid;
    assign ar_hs  = arvalid_q & m_axi_lite_arready;
    assign r_hs   = rready_q & m_axi_lite_rvalid;
    assign expire = (TIMEOUT_W != '0) && (tmo_cnt == TIMEOUT_W - 32'd1);

    // Anything still outstanding once this cycle's handshakes have landed;
    // lets DRAIN release in the same cycle the last late response arrives.
    assign pend_next = (awvalid_q & ~m_axi_lite_awready) | (wvalid_q & ~m_axi_lite_wready)
                     | (arvalid_q & ~m_axi_lite_arready) | (b_pend & ~b_hs) | (r_pend & ~r_hs);

    assign m_axi_lite_awaddr  = addr_q;
    assign m_axi_lite_awprot  = 3'b000;
    assign m_axi_lite_awvalid = awvalid_q;
    assign m_axi_lite_wdata   = wdata_q;
    assign m_axi_lite_wstrb   = wstrb_q;
    assign m_axi_lite_wvalid  = wvalid_q;
    assign m_axi_lite_bready  = bready_q;
    assign m_axi_lite_araddr  = addr_q;
    assign m_axi_lite_arprot  = 3'b000;
    assign m_axi_lite_arvalid = arvalid_q;
    assign m_axi_lite_rready  = rready_q;

    // Next-state decode; a B/R handshake and a timeout both leave BUSY
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept) state_next = BUSY;
            BUSY:    if (b_hs || r_hs || expire) state_next = RESP;
            RESP:    if (rsp_valid && rsp_ready) state_next = pend_next ? DRAIN : IDLE;
            DRAIN:   if (!pend_next) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State register; cmd_ready is registered so it stays low during reset
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state     <= IDLE;
            cmd_ready <= 1'b0;
        end else begin
            state     <= state_next;
            cmd_ready <= (state_next == IDLE);
        end
    end

    // Command capture and per-channel pending flags; valids drop only on their handshake
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            awvalid_q <= 1'b0;
            wvalid_q  <= 1'b0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            rready_q  <= 1'b0;
            b_pend    <= 1'b0;
            r_pend    <= 1'b0;
        end else begin
            if (accept) begin
                addr_q  <= cmd_addr;
                wdata_q <= cmd_wdata;
                wstrb_q <= cmd_wstrb;
                if (cmd_write) begin
                    awvalid_q <= 1'b1;
                    wvalid_q  <= 1'b1;
                    b_pend    <= 1'b1;
                end else begin
                    arvalid_q <= 1'b1;
                    r_pend    <= 1'b1;
                end
            end
            if (aw_hs) awvalid_q <= 1'b0;
            if (w_hs)  wvalid_q  <= 1'b0;
            if (b_pend && !bready_q && (!awvalid_q || m_axi_lite_awready)
                && (!wvalid_q || m_axi_lite_wready))
                bready_q <= 1'b1;
            if (b_hs) begin
                bready_q <= 1'b0;
                b_pend   <= 1'b0;
            end
            if (ar_hs) begin
                arvalid_q <= 1'b0;
                rready_q  <= 1'b1;
            end
            if (r_hs) begin
                rready_q <= 1'b0;
                r_pend   <= 1'b0;
            end
        end
    end

    // Timeout counter: cleared on accept, advances only while BUSY
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) tmo_cnt <= '0;
        else if (accept) tmo_cnt <= '0;
        else if (state == BUSY) tmo_cnt <= tmo_cnt + 32'd1;
    end

    // Response capture; late B/R arriving in RESP/DRAIN is not captured
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rsp_valid   <= 1'b0;
            rsp_rdata   <= '0;
            rsp_resp    <= '0;
            rsp_timeout <= 1'b0;
        end else if (state == BUSY) begin
            if (b_hs) begin
                rsp_valid   <= 1'b1;
                rsp_rdata   <= '0;
                rsp_resp    <= m_axi_lite_bresp;
                rsp_timeout <= 1'b0;
            end else if (r_hs) begin
                rsp_valid   <= 1'b1;
                rsp_rdata   <= m_axi_lite_rdata;
                rsp_resp    <= m_axi_lite_rresp;
                rsp_timeout <= 1'b0;
            end else if (expire) begin
                rsp_valid   <= 1'b1;
                rsp_rdata   <= '0;
                rsp_resp    <= 2'b10;
                rsp_timeout <= 1'b1;
            end
        end else if (state == RESP && rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi4lite_cmd_manager.sv
// Directed bench for axi4lite_cmd_manager: subordinate handshake signals are
// driven as per-test levels, expected values are hand-derived cycle by cycle.
module tb_axi4lite_cmd_manager;

    logic        aclk = 1'b0;
    logic        aresetn;
    logic        cmd_valid, cmd_ready, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wstrb;
    logic        rsp_valid, rsp_ready, rsp_timeout;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_resp;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [2:0]  awprot, arprot;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;

    int n_checks = 0;
    int n_errors = 0;
    int b_cnt = 0;
    int r_cnt = 0;
    int base;
    logic [31:0] aw_seen, w_seen, ar_seen;
    logic [3:0]  wstrb_seen;

    always #5 aclk = ~aclk;

    axi4lite_cmd_manager #(.TIMEOUT_CYCLES(8)) dut (
        .aclk(aclk), .aresetn(aresetn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_resp(rsp_resp), .rsp_timeout(rsp_timeout),
        .m_axi_lite_awaddr(awaddr), .m_axi_lite_awprot(awprot),
        .m_axi_lite_awvalid(awvalid), .m_axi_lite_awready(awready),
        .m_axi_lite_wdata(wdata), .m_axi_lite_wstrb(wstrb),
        .m_axi_lite_wvalid(wvalid), .m_axi_lite_wready(wready),
        .m_axi_lite_bresp(bresp), .m_axi_lite_bvalid(bvalid), .m_axi_lite_bready(bready),
        .m_axi_lite_araddr(araddr), .m_axi_lite_arprot(arprot),
        .m_axi_lite_arvalid(arvalid), .m_axi_lite_arready(arready),
        .m_axi_lite_rdata(rdata), .m_axi_lite_rresp(rresp),
        .m_axi_lite_rvalid(rvalid), .m_axi_lite_rready(rready)
    );

    // Subordinate-side record of what actually crossed each channel
    always @(posedge aclk) begin
        if (awvalid && awready) aw_seen <= awaddr;
        if (wvalid && wready) begin
            w_seen     <= wdata;
            wstrb_seen <= wstrb;
        end
        if (arvalid && arready) ar_seen <= araddr;
        if (bvalid && bready) b_cnt <= b_cnt + 1;
        if (rvalid && rready) r_cnt <= r_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got 0x%08h exp 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    // Offer one command for exactly one cycle; returns #1 after the accept edge
    task automatic issue(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        check_eq("issue_cmd_ready", 32'(cmd_ready), 32'd1);
        cmd_valid = 1'b1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_wstrb = s;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input string tag, input logic [31:0] exp_rdata, input logic [1:0] exp_resp,
                            input logic exp_tmo);
        for (int i = 0; i < 40 && !rsp_valid; i++) step();
        check_eq({tag, "_seen"}, 32'(rsp_valid), 32'd1);
        check_eq({tag, "_rdata"}, rsp_rdata, exp_rdata);
        check_eq({tag, "_resp"}, 32'(rsp_resp), 32'(exp_resp));
        check_eq({tag, "_tmo"}, 32'(rsp_timeout), 32'(exp_tmo));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        aresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
        cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0; rsp_ready = 1'b0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bresp = 2'b00;
        arready = 1'b0; rvalid = 1'b0; rresp = 2'b00; rdata = '0;

        // Reset state
        #1;
        check_eq("rst_cmd_ready", 32'(cmd_ready), 32'd0);
        check_eq("rst_valids", 32'({awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 32'd0);
        check_eq("rst_rsp", {rsp_rdata[29:0], rsp_resp}, 32'd0);
        #22;
        aresetn = 1'b1;
        step();
        check_eq("post_rst_ready", 32'(cmd_ready), 32'd1);
        check_eq("prot", 32'({awprot, arprot}), 32'd0);

        // 1: zero-wait write, latency T+1 AW/W, T+2 B, T+3 rsp
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bresp = 2'b00; rsp_ready = 1'b1;
        base = b_cnt;
        issue(1'b1, 32'h0000_0104, 32'h0000_0064, 4'hF);
        check_eq("w1_ready_low", 32'(cmd_ready), 32'd0);
        check_eq("w1_aw_w_valid", 32'({awvalid, wvalid}), 32'b11);
        step();
        check_eq("w1_aw_w_drop", 32'({awvalid, wvalid}), 32'b00);
        check_eq("w1_bready", 32'(bready), 32'd1);
        check_eq("w1_awaddr", aw_seen, 32'h0000_0104);
        check_eq("w1_wdata", w_seen, 32'h0000_0064);
        check_eq("w1_wstrb", 32'(wstrb_seen), 32'hF);
        step();
        check_eq("w1_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("w1_rsp_resp", 32'(rsp_resp), 32'd0);
        check_eq("w1_rsp_tmo", 32'(rsp_timeout), 32'd0);
        check_eq("w1_rsp_rdata", rsp_rdata, 32'd0);
        step();
        check_eq("w1_rsp_done", 32'(rsp_valid), 32'd0);
        check_eq("w1_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("w1_b_count", 32'(b_cnt - base), 32'd1);

        // 2: wready leads awready by 3 cycles
        awready = 1'b0; wready = 1'b1; bvalid = 1'b1;
        base = b_cnt;
        issue(1'b1, 32'h0000_0108, 32'hA5A5_0001, 4'h3);
        step();
        check_eq("w2_w_first", 32'({awvalid, wvalid}), 32'b10);
        check_eq("w2_bready_wait", 32'(bready), 32'd0);
        step();
        step();
        check_eq("w2_aw_held", 32'(awvalid), 32'd1);
        awready = 1'b1;
        step();
        check_eq("w2_aw_drop", 32'(awvalid), 32'd0);
        check_eq("w2_bready", 32'(bready), 32'd1);
        step();
        check_eq("w2_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("w2_rsp_resp", 32'(rsp_resp), 32'd0);
        check_eq("w2_rsp_tmo", 32'(rsp_timeout), 32'd0);
        step();
        check_eq("w2_b_count", 32'(b_cnt - base), 32'd1);
        check_eq("w2_rsp_single", 32'(rsp_valid), 32'd0);
        check_eq("w2_awaddr", aw_seen, 32'h0000_0108);
        bvalid = 1'b0;

        // 3: read 0x100 with rsp_ready held low for 4 cycles
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h0000_0005; rresp = 2'b00; rsp_ready = 1'b0;
        base = r_cnt;
        issue(1'b0, 32'h0000_0100, 32'h0, 4'h0);
        check_eq("r3_arvalid", 32'(arvalid), 32'd1);
        step();
        check_eq("r3_ar_drop", 32'(arvalid), 32'd0);
        check_eq("r3_rready", 32'(rready), 32'd1);
        check_eq("r3_araddr", ar_seen, 32'h0000_0100);
        step();
        rdata = 32'hDEAD_BEEF;
        for (int i = 0; i < 4; i++) begin
            check_eq("r3_hold_valid", 32'(rsp_valid), 32'd1);
            check_eq("r3_hold_rdata", rsp_rdata, 32'h0000_0005);
            check_eq("r3_hold_busy", 32'(cmd_ready), 32'd0);
            step();
        end
        check_eq("r3_rsp_resp", 32'(rsp_resp), 32'd0);
        rsp_ready = 1'b1;
        step();
        check_eq("r3_accepted", 32'(rsp_valid), 32'd0);
        check_eq("r3_cmd_ready", 32'(cmd_ready), 32'd1);
        check_eq("r3_r_count", 32'(r_cnt - base), 32'd1);

        // 4: unmapped read returns SLVERR
        rdata = 32'h0; rresp = 2'b10;
        issue(1'b0, 32'h0000_0200, 32'h0, 4'h0);
        wait_rsp("r4", 32'h0, 2'b10, 1'b0);
        step();
        check_eq("r4_cmd_ready", 32'(cmd_ready), 32'd1);
        rvalid = 1'b0; rresp = 2'b00;

        // 5: subordinate never answers B -> timeout after 8 BUSY cycles, then drain
        awready = 1'b1; wready = 1'b1; bvalid = 1'b0;
        base = b_cnt;
        issue(1'b1, 32'h0000_010C, 32'h1234_0000, 4'hF);
        step();
        check_eq("t5_bready", 32'(bready), 32'd1);
        repeat (6) step();
        check_eq("t5_not_yet", 32'(rsp_valid), 32'd0);
        step();
        check_eq("t5_rsp_valid", 32'(rsp_valid), 32'd1);
        check_eq("t5_rsp_tmo", 32'(rsp_timeout), 32'd1);
        check_eq("t5_rsp_resp", 32'(rsp_resp), 32'b10);
        check_eq("t5_rsp_rdata", rsp_rdata, 32'd0);
        check_eq("t5_bready_kept", 32'(bready), 32'd1);
        step();
        rsp_ready = 1'b0;
        check_eq("t5_rsp_taken", 32'(rsp_valid), 32'd0);
        check_eq("t5_drain_busy", 32'(cmd_ready), 32'd0);
        step();
        step();
        check_eq("t5_drain_hold", 32'({cmd_ready, bready}), 32'b01);
        bvalid = 1'b1;
        step();
        bvalid = 1'b0;
        check_eq("t5_drain_exit", 32'(cmd_ready), 32'd1);
        check_eq("t5_bready_drop", 32'(bready), 32'd0);
        check_eq("t5_discarded", 32'(rsp_valid), 32'd0);
        check_eq("t5_b_count", 32'(b_cnt - base), 32'd1);

        // 6: reset while arvalid is high, then a normal read
        arready = 1'b0;
        issue(1'b0, 32'h0000_0100, 32'h0, 4'h0);
        step();
        check_eq("x6_ar_held", 32'(arvalid), 32'd1);
        #2;
        aresetn = 1'b0;
        #1;
        check_eq("x6_rst_valids", 32'({awvalid, wvalid, arvalid, bready, rready, rsp_valid}), 32'd0);
        check_eq("x6_rst_ready", 32'(cmd_ready), 32'd0);
        @(negedge aclk);
        aresetn = 1'b1;
        step();
        check_eq("x6_idle", 32'(cmd_ready), 32'd1);
        arready = 1'b1; rvalid = 1'b1; rdata = 32'h1234_5678; rresp = 2'b00;
        issue(1'b0, 32'h0000_0110, 32'h0, 4'h0);
        wait_rsp("x6", 32'h1234_5678, 2'b00, 1'b0);
        check_eq("x6_araddr", ar_seen, 32'h0000_0110);
        rsp_ready = 1'b1;
        step();
        rsp_ready = 1'b0;
        rvalid = 1'b0;
        check_eq("x6_cmd_ready", 32'(cmd_ready), 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
